// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX operand preparation.
// Define FWD_EN to build the MEM/WB operand forwarding muxes; without it the latched register values drive the ALU.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_aluop,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic [2:0]        id_m_ctl,
    input  logic [1:0]        id_wb_ctl,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [2:0]        ex_m_ctl,
    output logic [1:0]        ex_wb_ctl
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [1:0]        aluop;
        logic              alusrc;
        logic              regdst;
        logic [2:0]        m_ctl;
        logic [1:0]        wb_ctl;
    } idex_t;

    idex_t q;
    idex_t cap;

    always_comb begin
        cap        = '0;
        cap.valid  = id_valid;
        cap.rd1    = id_rd1;
        cap.rd2    = id_rd2;
        cap.imm    = id_imm;
        cap.rs     = id_rs;
        cap.rt     = id_rt;
        cap.rd     = id_rd;
        cap.aluop  = id_aluop;
        cap.alusrc = id_alusrc;
        cap.regdst = id_regdst;
        cap.m_ctl  = id_m_ctl;
        cap.wb_ctl = id_wb_ctl;
    end

    // Flush beats stall; an invalid ID slot is captured as a full bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (!stall)
            q <= id_valid ? cap : '0;
    end

    always_comb begin
        alu_control = 3'b010;
        case (q.aluop)
            2'b01: alu_control = 3'b110;
            2'b10: begin
                case (q.imm[5:0])
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b010;
        endcase
    end

    logic [DATA_W-1:0] fa;
    logic [DATA_W-1:0] fb;

`ifdef FWD_EN
    logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

    // Register 0 is hardwired, so a write to it never forwards.
    assign mem_hit_a = mem_regwrite && (mem_rd != '0) && (mem_rd == q.rs);
    assign mem_hit_b = mem_regwrite && (mem_rd != '0) && (mem_rd == q.rt);
    assign wb_hit_a  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == q.rs);
    assign wb_hit_b  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == q.rt);

    always_comb begin
        fa = q.rd1;
        fb = q.rd2;
        if (mem_hit_a)     fa = mem_data;
        else if (wb_hit_a) fa = wb_data;
        if (mem_hit_b)     fb = mem_data;
        else if (wb_hit_b) fb = wb_data;
    end
`else
    logic unused_fwd;

    assign fa = q.rd1;
    assign fb = q.rd2;
    assign unused_fwd = ^{mem_regwrite, mem_rd, mem_data, wb_regwrite, wb_rd, wb_data, q.rs, q.rt};
`endif

    assign alu_a         = fa;
    assign alu_b         = q.alusrc ? q.imm : fb;
    assign ex_store_data = fb;
    assign ex_dest       = q.regdst ? q.rd : q.rt;
    assign ex_valid      = q.valid;
    assign ex_m_ctl      = q.m_ctl;
    assign ex_wb_ctl     = q.wb_ctl;

endmodule
